pb_out_port_demux: RTL and testbench

- Output-side port decoder for a KCPSM3 PicoBlaze core: the write-direction counterpart of the input-port multiplexer.
- Decodes port_id during write_strobe and steers out_port into one of NUM_PORTS registered 8-bit output ports, raising a one-cycle write pulse for that port.
- Adds indexed read-modify-write operations (bit set/clear/toggle, auto-increment stream write) so firmware can drive peripheral control bits without shadow copies.
- Also supplies registered read-back of every port for the input mux.

---
 rtl/pb_io_pkg.sv | 36 +++
 rtl/pb_out_port_demux_if.sv | 35 +++
 rtl/pb_out_reg_slice.sv | 45 ++++
 rtl/pb_out_port_demux.sv | 106 ++++++++++
 tb/tb_pb_out_port_demux.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/pb_io_pkg.sv
// Shared types and offsets for the PicoBlaze output port demux.
// Offsets are relative to the 32-address window base.
package pb_io_pkg;

  localparam int WINDOW = 32;
  localparam int OFF_BITS = $clog2(WINDOW);

  localparam logic [OFF_BITS-1:0] OFF_IDX    = 5'd16;
  localparam logic [OFF_BITS-1:0] OFF_OR     = 5'd17;
  localparam logic [OFF_BITS-1:0] OFF_CLR    = 5'd18;
  localparam logic [OFF_BITS-1:0] OFF_XOR    = 5'd19;
  localparam logic [OFF_BITS-1:0] OFF_STREAM = 5'd20;

  typedef enum logic [1:0] {
    OP_WR,
    OP_OR,
    OP_CLR,
    OP_XOR
  } op_e;

  // STREAM is a plain load into the indexed register.
  function automatic op_e off2op(
    input logic [OFF_BITS-1:0] off
  );
    op_e op;
    op = OP_WR;
    case (off)
      OFF_OR:  op = OP_OR;
      OFF_CLR: op = OP_CLR;
      OFF_XOR: op = OP_XOR;
      default: op = OP_WR;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/pb_out_port_demux_if.sv
// PicoBlaze write bus plus the demux result signals.
// master = processor side, slave = demux side.
interface pb_out_port_demux_if #(
  parameter int NUM_PORTS = 8
);

  logic [7:0]             port_id;
  logic                   write_strobe;
  logic [7:0]             out_port;
  logic [8*NUM_PORTS-1:0] port_q;
  logic [NUM_PORTS-1:0]   port_wr_pulse;
  logic [7:0]             rd_data;
  logic                   err_pulse;

  modport master (
    output port_id,
    output write_strobe,
    output out_port,
    input  port_q,
    input  port_wr_pulse,
    input  rd_data,
    input  err_pulse
  );

  modport slave (
    input  port_id,
    input  write_strobe,
    input  out_port,
    output port_q,
    output port_wr_pulse,
    output rd_data,
    output err_pulse
  );

endinterface

// File: rtl/pb_out_reg_slice.sv
// One 8-bit output register with load/or/clear/xor update
// and a one-cycle pulse marking each update.
module pb_out_reg_slice
  import pb_io_pkg::*;
#(
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  op_e        op_i,
  input  logic [7:0] din_i,
  output logic [7:0] q_o,
  output logic       pulse_o
);

  logic [7:0] q_q, q_d;
  logic       pulse_q;

  // Next value of the register for the selected operation.
  always_comb begin
    q_d = q_q;
    unique case (op_i)
      OP_WR:  q_d = din_i;
      OP_OR:  q_d = q_q | din_i;
      OP_CLR: q_d = q_q & ~din_i;
      OP_XOR: q_d = q_q ^ din_i;
    endcase
  end

  // Register update and write pulse, reset wins over enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q     <= RESET_VAL;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= en_i;
      if (en_i) q_q <= q_d;
    end
  end

  assign q_o     = q_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/pb_out_port_demux.sv
// PicoBlaze output port decoder: direct and indexed RMW
// writes into NUM_PORTS registers, plus registered read-back.
module pb_out_port_demux
  import pb_io_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter int         NUM_PORTS = 8,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input logic               clk,
  input logic               reset,
  pb_out_port_demux_if.slave bus
);

  localparam logic [4:0] NP = 5'(NUM_PORTS);
  localparam logic [3:0] LAST = 4'(NUM_PORTS - 1);

  logic                 hit, wr, idx_ok;
  logic [4:0]           off;
  logic [3:0]           idx_q, idx_d;
  logic                 err_q, err_d;
  logic [7:0]           rd_q, rd_d;
  logic [NUM_PORTS-1:0] en;
  op_e                  op;
  logic [7:0]           regs [NUM_PORTS];

  assign hit    = bus.port_id[7:OFF_BITS] == BASE_ADDR[7:OFF_BITS];
  assign off    = bus.port_id[OFF_BITS-1:0];
  assign wr     = bus.write_strobe & hit;
  assign idx_ok = {1'b0, idx_q} < NP;

  // Write decode: port enables, op, index update, error.
  always_comb begin
    en    = '0;
    op    = OP_WR;
    idx_d = idx_q;
    err_d = 1'b0;
    if (wr) begin
      unique case (1'b1)
        (off < NP): begin
          for (int i = 0; i < NUM_PORTS; i++)
            if (off == 5'(i)) en[i] = 1'b1;
        end
        (off >= NP && off < OFF_IDX): err_d = 1'b1;
        (off == OFF_IDX): idx_d = bus.out_port[3:0];
        (off >= OFF_OR && off <= OFF_STREAM): begin
          if (idx_ok) begin
            op = off2op(off);
            for (int i = 0; i < NUM_PORTS; i++)
              if (idx_q == 4'(i)) en[i] = 1'b1;
            if (off == OFF_STREAM)
              idx_d = (idx_q == LAST) ? 4'd0 : idx_q + 4'd1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Read-back source selection, sampled before any write lands.
  always_comb begin
    rd_d = 8'h00;
    if (hit) begin
      if (off < NP) begin
        for (int i = 0; i < NUM_PORTS; i++)
          if (off == 5'(i)) rd_d = regs[i];
      end else if (off == OFF_IDX) begin
        rd_d = {4'b0000, idx_q};
      end
    end
  end

  // Index pointer, error pulse and read-back registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= 4'd0;
      err_q <= 1'b0;
      rd_q  <= 8'h00;
    end else begin
      idx_q <= idx_d;
      err_q <= err_d;
      rd_q  <= rd_d;
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_slice
    pb_out_reg_slice #(
      .RESET_VAL(RESET_VAL)
    ) u_slice (
      .clk    (clk),
      .reset  (reset),
      .en_i   (en[g]),
      .op_i   (op),
      .din_i  (bus.out_port),
      .q_o    (regs[g]),
      .pulse_o(bus.port_wr_pulse[g])
    );
    assign bus.port_q[8*g +: 8] = regs[g];
  end

  assign bus.rd_data   = rd_q;
  assign bus.err_pulse = err_q;

endmodule

// File: tb/tb_pb_out_port_demux.sv
// Directed vector bench for pb_out_port_demux,
// BASE_ADDR=8'h40, NUM_PORTS=8, RESET_VAL=8'h00.
module tb_pb_out_port_demux;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pb_out_port_demux_if #(.NUM_PORTS(8)) bus ();

  pb_out_port_demux #(
    .BASE_ADDR(8'h40),
    .NUM_PORTS(8),
    .RESET_VAL(8'h00)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic        rst;
    logic        stb;
    logic [7:0]  pid;
    logic [7:0]  dout;
    logic [63:0] q;
    logic [7:0]  pls;
    logic        err;
    logic [7:0]  rd;
  } vec_t;

  localparam int NV = 29;
  vec_t tv [NV];
  int n_vec = 0;
  int n_miss = 0;

  function automatic vec_t mk(
    input logic        rst,
    input logic        stb,
    input logic [7:0]  pid,
    input logic [7:0]  dout,
    input logic [63:0] q,
    input logic [7:0]  pls,
    input logic        err,
    input logic [7:0]  rd
  );
    vec_t v;
    v.rst = rst; v.stb = stb; v.pid = pid; v.dout = dout;
    v.q = q; v.pls = pls; v.err = err; v.rd = rd;
    return v;
  endfunction

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all(
    input int          k,
    input logic [63:0] q,
    input logic [7:0]  pls,
    input logic        err,
    input logic [7:0]  rd
  );
    n_vec++;
    chk($sformatf("v%0d port_q", k), bus.port_q, q);
    chk($sformatf("v%0d pulse", k), {56'd0, bus.port_wr_pulse}, {56'd0, pls});
    chk($sformatf("v%0d err", k), {63'd0, bus.err_pulse}, {63'd0, err});
    chk($sformatf("v%0d rd", k), {56'd0, bus.rd_data}, {56'd0, rd});
  endtask

  task automatic drive(
    input logic       rst,
    input logic       stb,
    input logic [7:0] pid,
    input logic [7:0] dout
  );
    @(negedge clk);
    reset            = rst;
    bus.write_strobe = stb;
    bus.port_id      = pid;
    bus.out_port     = dout;
  endtask

  initial begin
    tv[0]  = mk(1, 0, 8'h00, 8'h00, 64'h00000000_00000000, 8'h00, 0, 8'h00);
    tv[1]  = mk(0, 1, 8'h43, 8'hA5, 64'h00000000_A5000000, 8'h08, 0, 8'h00);
    tv[2]  = mk(0, 0, 8'h43, 8'h00, 64'h00000000_A5000000, 8'h00, 0, 8'hA5);
    tv[3]  = mk(0, 1, 8'h42, 8'hF0, 64'h00000000_A5F00000, 8'h04, 0, 8'h00);
    tv[4]  = mk(0, 1, 8'h50, 8'h02, 64'h00000000_A5F00000, 8'h00, 0, 8'h00);
    tv[5]  = mk(0, 1, 8'h51, 8'h0F, 64'h00000000_A5FF0000, 8'h04, 0, 8'h00);
    tv[6]  = mk(0, 1, 8'h52, 8'h81, 64'h00000000_A57E0000, 8'h04, 0, 8'h00);
    tv[7]  = mk(0, 1, 8'h53, 8'hFF, 64'h00000000_A5810000, 8'h04, 0, 8'h00);
    tv[8]  = mk(0, 1, 8'h50, 8'h06, 64'h00000000_A5810000, 8'h00, 0, 8'h02);
    tv[9]  = mk(0, 1, 8'h54, 8'h11, 64'h00110000_A5810000, 8'h40, 0, 8'h00);
    tv[10] = mk(0, 1, 8'h54, 8'h22, 64'h22110000_A5810000, 8'h80, 0, 8'h00);
    tv[11] = mk(0, 1, 8'h54, 8'h33, 64'h22110000_A5810033, 8'h01, 0, 8'h00);
    tv[12] = mk(0, 1, 8'h54, 8'h44, 64'h22110000_A5814433, 8'h02, 0, 8'h00);
    tv[13] = mk(0, 0, 8'h50, 8'h00, 64'h22110000_A5814433, 8'h00, 0, 8'h02);
    tv[14] = mk(0, 1, 8'h50, 8'h09, 64'h22110000_A5814433, 8'h00, 0, 8'h02);
    tv[15] = mk(0, 1, 8'h51, 8'hFF, 64'h22110000_A5814433, 8'h00, 1, 8'h00);
    tv[16] = mk(0, 1, 8'h4A, 8'h55, 64'h22110000_A5814433, 8'h00, 1, 8'h00);
    tv[17] = mk(0, 1, 8'h83, 8'h77, 64'h22110000_A5814433, 8'h00, 0, 8'h00);
    tv[18] = mk(0, 1, 8'h45, 8'h3C, 64'h22113C00_A5814433, 8'h20, 0, 8'h00);
    tv[19] = mk(0, 0, 8'h45, 8'h00, 64'h22113C00_A5814433, 8'h00, 0, 8'h3C);
    tv[20] = mk(0, 0, 8'h45, 8'h00, 64'h22113C00_A5814433, 8'h00, 0, 8'h3C);
    tv[21] = mk(0, 0, 8'h5F, 8'h00, 64'h22113C00_A5814433, 8'h00, 0, 8'h00);
    tv[22] = mk(0, 0, 8'h50, 8'h00, 64'h22113C00_A5814433, 8'h00, 0, 8'h09);
    tv[23] = mk(0, 1, 8'h40, 8'h01, 64'h22113C00_A5814401, 8'h01, 0, 8'h33);
    tv[24] = mk(0, 1, 8'h41, 8'h02, 64'h22113C00_A5810201, 8'h02, 0, 8'h44);
    tv[25] = mk(1, 1, 8'h40, 8'hAA, 64'h00000000_00000000, 8'h00, 0, 8'h00);
    tv[26] = mk(0, 0, 8'h50, 8'h00, 64'h00000000_00000000, 8'h00, 0, 8'h00);
    tv[27] = mk(0, 1, 8'h54, 8'h5A, 64'h00000000_0000005A, 8'h01, 0, 8'h00);
    tv[28] = mk(0, 0, 8'h50, 8'h00, 64'h00000000_0000005A, 8'h00, 0, 8'h01);

    reset            = 1'b1;
    bus.write_strobe = 1'b0;
    bus.port_id      = 8'h00;
    bus.out_port     = 8'h00;
    repeat (2) @(posedge clk);

    for (int k = 0; k < NV; k++) begin
      drive(tv[k].rst, tv[k].stb, tv[k].pid, tv[k].dout);
      @(posedge clk);
      #1;
      check_all(k, tv[k].q, tv[k].pls, tv[k].err, tv[k].rd);
    end

    // Nothing may change before the edge that samples the strobe.
    drive(0, 1, 8'h44, 8'h99);
    #1;
    check_all(100, 64'h00000000_0000005A, 8'h00, 0, 8'h01);
    @(posedge clk);
    #1;
    check_all(101, 64'h00000099_0000005A, 8'h10, 0, 8'h00);
    drive(0, 0, 8'h44, 8'h00);
    @(posedge clk);
    #1;
    check_all(102, 64'h00000099_0000005A, 8'h00, 0, 8'h99);

    // Error pulse lasts exactly one cycle.
    drive(0, 1, 8'h4F, 8'hFF);
    @(posedge clk);
    #1;
    check_all(103, 64'h00000099_0000005A, 8'h00, 1, 8'h00);
    drive(0, 0, 8'h4F, 8'h00);
    @(posedge clk);
    #1;
    check_all(104, 64'h00000099_0000005A, 8'h00, 0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
